// File: rtl/fifo_rr_drain_arbiter_pkg.sv
// Shared arbiter definitions: boolean constants, width helpers and FSM state codes.
// Imported by fifo_rr_drain_arbiter and rr_pick.
package fifo_rr_drain_arbiter_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_BURST = 1'b1;

    typedef enum logic {
        S_IDLE  = ARB_IDLE,
        S_BURST = ARB_BURST
    } arb_state_e;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Index width for an N-way selector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_pick.sv
// rr_pick: combinational round-robin search. Returns the first requester found at
// ptr, ptr+1, ... wrapping modulo N, plus a flag that any request is present.
module rr_pick
    import fifo_rr_drain_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0] cand;
    logic       found;

    // Walk offsets from the pointer; the first hit latches and later offsets are ignored.
    always_comb begin
        idx   = '0;
        any   = FALSE;
        cand  = '0;
        found = FALSE;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (W+1)'(k);
            if (cand > (W+1)'(N - 1)) begin
                cand = cand - (W+1)'(N);
            end
            if (!found && req[cand[W-1:0]]) begin
                idx   = cand[W-1:0];
                found = TRUE;
            end
        end
        any = found;
    end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain of N FWFT FIFOs into one downstream write port, BURST words per grant.
// Optional macro ARB_SRC_TAG_EN adds out_src, the source index registered with each word.
module fifo_rr_drain_arbiter
    import fifo_rr_drain_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int BURST = 16,
    parameter int DELAY = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N-1:0]           in_empty,
    input  logic [N*WIDTH-1:0]     in_dout,
    output logic [N-1:0]           in_rden,
    input  logic                   out_almost_full,
    output logic                   out_wren,
    output logic [WIDTH-1:0]       out_din,
`ifdef ARB_SRC_TAG_EN
    output logic [idx_width(N)-1:0] out_src,
`endif
    output logic                   busy
);

    localparam int GW = idx_width(N);
    localparam int BW = clog2(BURST + 1);
    localparam logic [N-1:0] ONE_HOT = N'(1);

    // DELAY is kept for interface compatibility; this RTL is zero-delay.
    if (N < 2 || N > 16 || BURST < 1 || WIDTH < 1 || DELAY < 0) begin : g_param_check
        $error("fifo_rr_drain_arbiter: illegal parameter set");
    end

    arb_state_e        state;
    arb_state_e        state_nxt;
    logic [GW-1:0]     grant;
    logic [GW-1:0]     grant_inc;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     pick_idx;
    logic              pick_any;
    logic [BW-1:0]     burst_cnt;
    logic              pop;
    logic              last_word;
    logic              ran_dry;
    logic [WIDTH-1:0]  src_word [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign src_word[i] = in_dout[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .N (N),
        .W (GW)
    ) u_pick (
        .req (~in_empty),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign last_word = (burst_cnt == BW'(BURST - 1));
    assign ran_dry   = in_empty[grant] && !out_almost_full;
    assign grant_inc = (grant == GW'(N - 1)) ? '0 : grant + GW'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if ((pop && last_word) || ran_dry) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pops are held off while RESET is high so no word leaves a source FIFO and is then dropped.
    always_comb begin
        pop     = FALSE;
        in_rden = '0;
        if (state == S_BURST && !RESET) begin
            pop = !in_empty[grant] && !out_almost_full;
            if (pop) begin
                in_rden = ONE_HOT << grant;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            out_wren  <= FALSE;
            out_din   <= '0;
            busy      <= FALSE;
        end else begin
            out_wren <= pop;
            busy     <= (state_nxt == S_BURST);
            if (state == S_IDLE && pick_any) begin
                grant     <= pick_idx;
                burst_cnt <= '0;
            end
            if (pop) begin
                burst_cnt <= burst_cnt + BW'(1);
                out_din   <= src_word[grant];
            end
            if (state == S_BURST && state_nxt == S_IDLE) begin
                rr_ptr <= grant_inc;
            end
        end
    end

`ifdef ARB_SRC_TAG_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_src <= '0;
        end else if (pop) begin
            out_src <= grant;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter (N=4, BURST=4): burst-level vector table, directed
// corner sequences and random traffic against a transaction-level arbitration model.
module tb_fifo_rr_drain_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int BURST = 4;

    logic                 CLK;
    logic                 RESET;
    logic [N-1:0]         in_empty;
    logic [N*WIDTH-1:0]   in_dout;
    logic [N-1:0]         in_rden;
    logic                 out_almost_full;
    logic                 out_wren;
    logic [WIDTH-1:0]     out_din;
    logic                 busy;
`ifdef ARB_SRC_TAG_EN
    logic [1:0]           out_src;
`endif

    fifo_rr_drain_arbiter #(
        .N     (N),
        .WIDTH (WIDTH),
        .BURST (BURST),
        .DELAY (1)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .in_empty        (in_empty),
        .in_dout         (in_dout),
        .in_rden         (in_rden),
        .out_almost_full (out_almost_full),
        .out_wren        (out_wren),
        .out_din         (out_din),
`ifdef ARB_SRC_TAG_EN
        .out_src         (out_src),
`endif
        .busy            (busy)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- bench state ----------------
    logic [WIDTH-1:0] src_q [N][$];
    logic [WIDTH-1:0] exp_q [$];
    int               obs_src [$];
    int               obs_len [$];
    bit               obs_new;
    int               total_pops;
    int               n_written;
    int               word_seq;
    int               n_tests;
    int               n_fail;
    bit               rst_req;
    bit               af_req;
    logic [N-1:0]     s_rden;
    logic             s_wren;
    logic             s_busy;

    // Arbitration model: burst owner, words taken, next search start, output register.
    bit               m_busy;
    int               m_src;
    int               m_cnt;
    int               m_ptr;
    bit               m_wr;
    logic [WIDTH-1:0] m_din;

    typedef struct packed {
        logic [15:0] cnt;   // words per source, one hex digit each, source 0 leftmost
        logic [3:0]  nb;    // expected number of bursts
        logic [31:0] gr;    // expected grant sequence, first burst leftmost digit
        logic [31:0] len;   // expected burst lengths, same order
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit queues_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic push(input int src, input int n);
        for (int j = 0; j < n; j++) begin
            src_q[src].push_back({8'(src), 24'(word_seq)});
            word_seq++;
        end
    endtask

    // One cycle: check registered outputs, drive inputs, check in_rden, advance the model.
    task automatic tick();
        logic [N-1:0]     exp_rden;
        logic [WIDTH-1:0] word;
        bit               pop;
        bit               was_empty;
        bit               found;
        int               s;
        @(negedge CLK);
        s_wren = out_wren;
        s_busy = busy;
        check("out_wren", out_wren, m_wr);
        check("out_din", out_din, m_din);
        check("busy", busy, m_busy);
        if (out_wren === 1'b1) begin
            n_written++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_word: got 0x%0h, expected no write at %0t", out_din, $time);
            end else begin
                check("sb_word", out_din, exp_q.pop_front());
            end
        end
        if (busy === 1'b0) obs_new = 1'b1;

        RESET           = rst_req;
        out_almost_full = af_req;
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (src_q[i].size() == 0);
            in_dout[i*WIDTH +: WIDTH] = (src_q[i].size() == 0) ? '0 : src_q[i][0];
        end
        #1;
        s_rden = in_rden;
        check("rden_onehot0", $onehot0(in_rden), 1'b1);

        if (in_rden != '0) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                if (in_rden[i]) s = i;
            end
            if (obs_new || obs_src.size() == 0) begin
                obs_src.push_back(s);
                obs_len.push_back(0);
                obs_new = 1'b0;
            end
            obs_len[obs_len.size()-1] = obs_len[obs_len.size()-1] + 1;
            total_pops++;
        end

        exp_rden = '0;
        if (rst_req) begin
            m_busy = 1'b0; m_src = 0; m_cnt = 0; m_ptr = 0;
            m_wr = 1'b0;   m_din = '0;
            exp_q.delete();
        end else begin
            was_empty = m_busy && (src_q[m_src].size() == 0);
            pop       = m_busy && !was_empty && !af_req;
            if (pop) begin
                exp_rden[m_src] = 1'b1;
                word  = src_q[m_src].pop_front();
                exp_q.push_back(word);
                m_din = word;
            end
            m_wr = pop;
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    s = (m_ptr + k) % N;
                    if (!found && src_q[s].size() > 0) begin
                        found = 1'b1;
                        m_src = s;
                    end
                end
                if (found) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                if (pop) m_cnt++;
                if ((pop && m_cnt == BURST) || (was_empty && !af_req)) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_src + 1) % N;
                end
            end
        end
        check("in_rden", in_rden, exp_rden);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (c < budget && !(queues_empty() && exp_q.size() == 0 && !m_busy)) begin
            tick();
            c++;
        end
        tick();
        n_tests++;
        if (c >= budget) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d cycles, expected under %0d", c, budget);
        end
    endtask

    task automatic clear_obs();
        obs_src.delete();
        obs_len.delete();
        obs_new    = 1'b1;
        total_pops = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        af_req  = 1'b0;
        rst_req = 1'b1;
        tick();
        tick();
        rst_req = 1'b0;
        clear_obs();
    endtask

    task automatic run_until_pops(input int target);
        int c;
        c = 0;
        while (c < 40 && total_pops < target) begin
            tick();
            c++;
        end
        check("pops_reached", total_pops, target);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sum;
        int g;
        int l;
        int n_pushed;
        n_tests = 0; n_fail = 0; word_seq = 1; n_written = 0;
        RESET = 1'b1; out_almost_full = 1'b0; in_empty = '1; in_dout = '0;
        rst_req = 1'b1; af_req = 1'b0;
        m_busy = 1'b0; m_src = 0; m_cnt = 0; m_ptr = 0; m_wr = 1'b0; m_din = '0;
        clear_obs();

        vecs[0] = '{cnt: 16'h00A0, nb: 4'd3, gr: 32'h222,    len: 32'h442};
        vecs[1] = '{cnt: 16'h8808, nb: 4'd6, gr: 32'h013013, len: 32'h444444};
        vecs[2] = '{cnt: 16'h1520, nb: 4'd4, gr: 32'h0121,   len: 32'h1421};
        vecs[3] = '{cnt: 16'h0003, nb: 4'd1, gr: 32'h3,      len: 32'h3};
        vecs[4] = '{cnt: 16'h6000, nb: 4'd2, gr: 32'h00,     len: 32'h42};
        vecs[5] = '{cnt: 16'h3031, nb: 4'd3, gr: 32'h023,    len: 32'h331};

        // Reset with all sources empty: nothing moves for three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rden", s_rden, '0);
            check("rst_wren", s_wren, 1'b0);
            check("rst_busy", s_busy, 1'b0);
        end
        rst_req = 1'b0;
        tick();

        // Burst-level vector table, each row from a fresh reset (search starts at 0).
        for (int t = 0; t < 6; t++) begin
            do_reset();
            sum = 0;
            for (int i = 0; i < N; i++) begin
                push(i, int'((vecs[t].cnt >> (4 * (N - 1 - i))) & 16'hF));
                sum += int'((vecs[t].cnt >> (4 * (N - 1 - i))) & 16'hF);
            end
            drain(400);
            check("vec_bursts", obs_src.size(), vecs[t].nb);
            check("vec_total", total_pops, sum);
            for (int k = 0; k < int'(vecs[t].nb); k++) begin
                g = int'((vecs[t].gr  >> (4 * (int'(vecs[t].nb) - 1 - k))) & 32'hF);
                l = int'((vecs[t].len >> (4 * (int'(vecs[t].nb) - 1 - k))) & 32'hF);
                if (k < obs_src.size()) begin
                    check("vec_grant", obs_src[k], g);
                    check("vec_len", obs_len[k], l);
                end
            end
        end

        // Early empty: source 1 runs dry after 2 words; the next search starts at 2.
        do_reset();
        push(1, 2);
        drain(100);
        check("early_bursts", obs_src.size(), 1);
        if (obs_len.size() > 0) check("early_len", obs_len[0], 2);
        clear_obs();
        push(0, 1);
        push(2, 1);
        drain(100);
        check("early_next_bursts", obs_src.size(), 2);
        if (obs_src.size() == 2) begin
            check("early_next_first", obs_src[0], 2);
            check("early_next_second", obs_src[1], 0);
        end

        // Backpressure after the third pop, five stalled cycles.
        do_reset();
        push(0, 6);
        run_until_pops(3);
        af_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rden", s_rden, '0);
            check("bp_busy", s_busy, 1'b1);
            if (i == 0) check("bp_wren_last", s_wren, 1'b1);
            else        check("bp_wren", s_wren, 1'b0);
        end
        af_req = 1'b0;
        drain(100);
        check("bp_bursts", obs_src.size(), 2);
        if (obs_len.size() == 2) begin
            check("bp_len0", obs_len[0], BURST);
            check("bp_len1", obs_len[1], 2);
        end

        // Source empty while stalled must not close the burst.
        do_reset();
        push(1, 2);
        run_until_pops(2);
        af_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_empty_busy", s_busy, 1'b1);
        end
        push(1, 1);
        af_req = 1'b0;
        drain(100);
        check("stall_empty_bursts", obs_src.size(), 1);
        if (obs_len.size() > 0) check("stall_empty_len", obs_len[0], 3);

        // Reset in the middle of a burst from source 3.
        do_reset();
        push(3, 4);
        run_until_pops(2);
        push(0, 2);
        rst_req = 1'b1;
        tick();
        check("midrst_rden", s_rden, '0);
        rst_req = 1'b0;
        tick();
        check("midrst_wren", s_wren, 1'b0);
        check("midrst_busy", s_busy, 1'b0);
        check("midrst_idle_rden", s_rden, '0);
        tick();
        check("midrst_src0_wins", s_rden, 4'b0001);
        drain(100);

        // Random traffic, random backpressure and rare resets.
        do_reset();
        n_written = 0;
        n_pushed  = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 99) < 25) begin
                l = $urandom_range(1, 3);
                g = $urandom_range(0, N - 1);
                if (src_q[g].size() < 24) begin
                    push(g, l);
                    n_pushed += l;
                end
            end
            af_req  = ($urandom_range(0, 3) == 0);
            rst_req = ($urandom_range(0, 499) == 0);
            tick();
        end
        af_req  = 1'b0;
        rst_req = 1'b0;
        drain(2000);
        check("rand_conservation", n_written, n_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
